// File: rtl/amm_slave_buffer.sv
// rtl/amm_slave_buffer.sv - Avalon-MM slave: DEPTH-word buffer, CSR window, clear sweep, access counters.
// Optional AMM_SLAVE_WAITSTATE_EN inserts one wait state before every accepted request.
module amm_slave_buffer #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    output logic [15:0]       debug_flag
);

    localparam int IDX_W = ADDR_W - 1;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               cnt_en_q, cnt_en_d;
    logic [31:0]        wr_count_q, wr_count_d;
    logic [31:0]        rd_count_q, rd_count_d;
    logic [31:0]        scratch_q, scratch_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_is_reg_q, s1_is_reg_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic [31:0]        s1_reg_q, s1_reg_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [31:0]        mem_q [0:DEPTH-1];

    logic               busy;
    logic               wr_acc, rd_acc, is_reg, clear_start;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         reg_sel;
    logic [31:0]        reg_rdata, merged;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [31:0]        mem_wdata;

    assign busy = (state_q == ST_CLEAR);

`ifdef AMM_SLAVE_WAITSTATE_EN
    logic ws_done_q, ws_done_d;
    // A request is held off for one cycle, then accepted; the flag drops on acceptance.
    assign avs_waitrequest = busy | ((avs_read | avs_write) & ~ws_done_q);
    assign ws_done_d       = (avs_read | avs_write) & ~ws_done_q & ~busy;
`else
    assign avs_waitrequest = busy;
`endif

    always_comb begin
        wr_acc  = avs_write & ~avs_waitrequest;
        rd_acc  = avs_read & ~avs_write & ~avs_waitrequest;
        is_reg  = avs_address[ADDR_W-1];
        idx     = avs_address[IDX_W-1:0];
        reg_sel = avs_address[2:0];

        case (reg_sel)
            3'd0:    reg_rdata = {30'b0, cnt_en_q, 1'b0};
            3'd1:    reg_rdata = {16'(DEPTH), 15'b0, busy};
            3'd2:    reg_rdata = wr_count_q;
            3'd3:    reg_rdata = rd_count_q;
            3'd4:    reg_rdata = scratch_q;
            default: reg_rdata = 32'b0;
        endcase

        clear_start = wr_acc & is_reg & (reg_sel == 3'd0) & avs_byteenable[0] & avs_writedata[0];
        cnt_en_d    = cnt_en_q;
        if (wr_acc && is_reg && reg_sel == 3'd0 && avs_byteenable[0])
            cnt_en_d = avs_writedata[1];

        // Register clear is applied last so it wins over a same-cycle increment.
        wr_count_d = wr_count_q;
        if (cnt_en_q && wr_acc && !is_reg)
            wr_count_d = wr_count_q + 32'd1;
        if (wr_acc && is_reg && reg_sel == 3'd2)
            wr_count_d = 32'd0;

        rd_count_d = rd_count_q;
        if (cnt_en_q && rd_acc && !is_reg)
            rd_count_d = rd_count_q + 32'd1;
        if (wr_acc && is_reg && reg_sel == 3'd3)
            rd_count_d = 32'd0;

        scratch_d = scratch_q;
        merged    = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (avs_byteenable[b]) begin
                merged[8*b +: 8] = avs_writedata[8*b +: 8];
                if (wr_acc && is_reg && reg_sel == 3'd4)
                    scratch_d[8*b +: 8] = avs_writedata[8*b +: 8];
            end
        end

        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        mem_we    = busy | (wr_acc & ~is_reg);
        mem_widx  = busy ? clr_idx_q : idx;
        mem_wdata = busy ? 32'b0 : merged;

        // Register reads are snapshotted at acceptance; buffer reads fetch in stage 2.
        s1_valid_d  = rd_acc;
        s1_is_reg_d = is_reg;
        s1_idx_d    = idx;
        s1_reg_d    = reg_rdata;

        rvalid_d = s1_valid_q;
        rdata_d  = rdata_q;
        if (s1_valid_q)
            rdata_d = s1_is_reg_q ? s1_reg_q : mem_q[s1_idx_q];
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            clr_idx_q   <= '0;
            cnt_en_q    <= 1'b0;
            wr_count_q  <= 32'd0;
            rd_count_q  <= 32'd0;
            scratch_q   <= 32'd0;
            s1_valid_q  <= 1'b0;
            s1_is_reg_q <= 1'b0;
            s1_idx_q    <= '0;
            s1_reg_q    <= 32'd0;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
`ifdef AMM_SLAVE_WAITSTATE_EN
            ws_done_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cnt_en_q    <= cnt_en_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            scratch_q   <= scratch_d;
            s1_valid_q  <= s1_valid_d;
            s1_is_reg_q <= s1_is_reg_d;
            s1_idx_q    <= s1_idx_d;
            s1_reg_q    <= s1_reg_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
`ifdef AMM_SLAVE_WAITSTATE_EN
            ws_done_q   <= ws_done_d;
`endif
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign debug_flag        = {busy, s1_valid_q, 6'b0, wr_count_q[7:0]};

endmodule

// File: tb/tb_amm_slave_buffer.sv
// tb/tb_amm_slave_buffer.sv - directed self-checking bench for amm_slave_buffer.
module tb_amm_slave_buffer;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic              avs_waitrequest;
    logic [15:0]       debug_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_data [$];
    int          acc_cyc  [$];
    logic [31:0] got_data [$];
    int          got_cyc  [$];

    amm_slave_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .debug_flag        (debug_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            got_data.push_back(avs_readdata);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = '0;
        avs_writedata  = 32'd0;
        avs_byteenable = 4'd0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic bus_op(input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
        int n;
        avs_address    = addr;
        avs_write      = wr;
        avs_read       = rd;
        avs_writedata  = wdata;
        avs_byteenable = be;
        #1;
        n = 0;
        while (avs_waitrequest === 1'b1 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check_val("accept_timeout", 32'd1, 32'd0);
        if (rd && !wr) begin
            exp_data.push_back(exp);
            acc_cyc.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic wr_word(input logic [ADDR_W-1:0] addr, input logic [31:0] d, input logic [3:0] be);
        bus_op(1'b1, 1'b0, addr, d, be, 32'd0);
    endtask

    task automatic rd_word(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        bus_op(1'b0, 1'b1, addr, 32'd0, 4'd0, exp);
    endtask

    task automatic compare_reads(input string tag);
        int n;
        bus_idle();
        repeat (4) @(negedge clk);
        check_val($sformatf("%s_count", tag), got_data.size(), exp_data.size());
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check_val($sformatf("%s_lat%0d", tag, i), got_cyc[i] - acc_cyc[i], 32'd2);
        end
        got_data.delete();
        got_cyc.delete();
        exp_data.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check_val("rst_readdata", avs_readdata, 32'd0);
        check_val("rst_rvalid", {31'd0, avs_readdatavalid}, 32'd0);
        check_val("rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
        check_val("rst_debug", {16'd0, debug_flag}, 32'd0);
        rd_word(9'h101, 32'h0100_0000);
        rd_word(9'h100, 32'd0);
        rd_word(9'h104, 32'd0);
        compare_reads("rst_regs");

        wr_word(9'd5, 32'hDEAD_BEEF, 4'hF);
        rd_word(9'd5, 32'hDEAD_BEEF);
        compare_reads("raw");

        wr_word(9'd7, 32'h1122_3344, 4'hF);
        wr_word(9'd7, 32'h0000_AA00, 4'b0010);
        rd_word(9'd7, 32'h1122_AA44);
        compare_reads("byteen");

        wr_word(9'd0, 32'hA000_0000, 4'hF);
        wr_word(9'd1, 32'hA000_0001, 4'hF);
        wr_word(9'd2, 32'hA000_0002, 4'hF);
        wr_word(9'd3, 32'hA000_0003, 4'hF);
        for (int i = 0; i < 4; i++) rd_word(ADDR_W'(i), 32'hA000_0000 + 32'(i));
        compare_reads("b2b");

        bus_op(1'b1, 1'b1, 9'd8, 32'h0000_0055, 4'hF, 32'd0);
        rd_word(9'd8, 32'h0000_0055);
        compare_reads("rdwr");

        wr_word(9'h100, 32'h0000_0002, 4'b0001);
        wr_word(9'd20, 32'h0000_0020, 4'hF);
        wr_word(9'd21, 32'h0000_0021, 4'hF);
        wr_word(9'd22, 32'h0000_0022, 4'hF);
        rd_word(9'd20, 32'h0000_0020);
        rd_word(9'd21, 32'h0000_0021);
        check_val("dbg_wrcnt", {24'd0, debug_flag[7:0]}, 32'd3);
        rd_word(9'h102, 32'd3);
        rd_word(9'h103, 32'd2);
        rd_word(9'h100, 32'd2);
        wr_word(9'h102, 32'hFFFF_FFFF, 4'hF);
        rd_word(9'h102, 32'd0);
        wr_word(9'h104, 32'hCAFE_F00D, 4'hF);
        wr_word(9'h104, 32'h1200_0000, 4'b1000);
        rd_word(9'h104, 32'h12FE_F00D);
        wr_word(9'h105, 32'h1234_5678, 4'hF);
        rd_word(9'h105, 32'd0);
        compare_reads("regs");

        wr_word(9'd10, 32'h0000_0077, 4'hF);
        wr_word(9'd200, 32'h0000_0088, 4'hF);
        rd_word(9'd10, 32'h0000_0077);
        wr_word(9'h100, 32'h0000_0003, 4'b0001);
        bus_idle();
        #1;
        n = 0;
        while (avs_waitrequest === 1'b1 && n < 1000) begin
            if (n == 100) check_val("clear_busy_dbg", {31'd0, debug_flag[15]}, 32'd1);
            @(negedge clk);
            #1;
            n++;
        end
        check_val("clear_wait_cycles", n, 32'd256);
        @(negedge clk);
        compare_reads("pre_clear");
        rd_word(9'd10, 32'd0);
        rd_word(9'd200, 32'd0);
        rd_word(9'd5, 32'd0);
        rd_word(9'h101, 32'h0100_0000);
        compare_reads("post_clear");

        wr_word(9'h100, 32'h0000_0001, 4'b0001);
        bus_idle();
        repeat (50) @(negedge clk);
        check_val("sweep_busy", {31'd0, debug_flag[15]}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("sweep_rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
        check_val("sweep_rst_debug", {16'd0, debug_flag}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("sweep_rst_readdata", avs_readdata, 32'd0);

        avs_address = 9'd3;
        avs_read    = 1'b1;
        @(negedge clk);
        bus_idle();
        check_val("s1_valid_dbg", {31'd0, debug_flag[14]}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("inflight_discard", got_data.size(), 32'd0);
        rd_word(9'h100, 32'd0);
        rd_word(9'h104, 32'd0);
        rd_word(9'h102, 32'd0);
        compare_reads("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
